da_play_sched: RTL

Playback scheduler for the two DA channel FIFOs (A and B) that the UDP receive controller fills. For each channel it paces FIFO reads at `freq × SPP` samples/s using a fractional phase accumulator. It gates playback on a prefill threshold, detects underrun and drives the registered 8-bit DA sample. Both channels run independently and identically; they sit between the FIFO read ports and the DAC interface.

---
 rtl/da_play_sched_if.sv | 37 +++
 rtl/da_play_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/da_play_sched_if.sv
// DA playback scheduler bus: channel controls, FIFO read ports, DA outputs.
// The controller/bench side is master; the scheduler is slave.
interface da_play_sched_if;
  logic        en_a;
  logic        en_b;
  logic [12:0] freq_a;
  logic [12:0] freq_b;
  logic [12:0] rd_data_count_a;
  logic [12:0] rd_data_count_b;
  logic [7:0]  fifo_out_a;
  logic [7:0]  fifo_out_b;
  logic        clr_status;
  logic        rd_en_a;
  logic        rd_en_b;
  logic [7:0]  da_data_a;
  logic [7:0]  da_data_b;
  logic [1:0]  state_a;
  logic [1:0]  state_b;
  logic        underrun_a;
  logic        underrun_b;

  modport master (
    output en_a, en_b, freq_a, freq_b,
    output rd_data_count_a, rd_data_count_b,
    output fifo_out_a, fifo_out_b, clr_status,
    input  rd_en_a, rd_en_b, da_data_a, da_data_b,
    input  state_a, state_b, underrun_a, underrun_b
  );

  modport slave (
    input  en_a, en_b, freq_a, freq_b,
    input  rd_data_count_a, rd_data_count_b,
    input  fifo_out_a, fifo_out_b, clr_status,
    output rd_en_a, rd_en_b, da_data_a, da_data_b,
    output state_a, state_b, underrun_a, underrun_b
  );
endinterface

// File: rtl/da_play_sched.sv
// DA playback scheduler: paces FIFO reads per channel with a
// fractional phase accumulator, prefill gating and underrun detect.
module da_play_ch #(
  parameter int         CLK_HZ  = 50_000_000,
  parameter int         SPP     = 256,
  parameter int         PREFILL = 10,
  parameter logic [7:0] MID     = 8'h80,
  parameter int         ACC_W   = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [12:0] freq,
  input  logic [12:0] count,
  input  logic [7:0]  fifo_out,
  input  logic        clr,
  output logic        rd_en,
  output logic [7:0]  da_data,
  output logic [1:0]  state_o,
  output logic        underrun
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRE    = 2'd1,
    PLAY   = 2'd2,
    STARVE = 2'd3
  } st_t;

  localparam int LG  = $clog2(SPP);
  localparam int SW0 = 13 + LG;
  localparam int SW  = (SW0 > ACC_W) ? SW0 : ACC_W;
  localparam logic [ACC_W-1:0] MOD = ACC_W'(CLK_HZ);

  st_t              state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic             rd_n;
  logic             pend, pend_n;
  logic [7:0]       da_n;
  logic             ur_n;

  logic [SW-1:0]    raw;
  logic [ACC_W-1:0] step;
  logic [ACC_W-1:0] sum;
  logic             tick;
  logic             go;
  logic             full;
  logic             avail;

  // freq*SPP as a shift, clamped so at most one tick per cycle
  assign raw   = SW'(freq) << LG;
  assign step  = (raw > SW'(CLK_HZ)) ? MOD : raw[ACC_W-1:0];
  assign sum   = acc + step;
  assign tick  = (sum >= MOD);
  assign go    = en && (freq != 13'd0);
  assign full  = (count >= 13'(PREFILL));
  assign avail = (count >= 13'd2);

  assign state_o = state;

  // next-state, accumulator and output decode
  always_comb begin
    state_n = state;
    acc_n   = acc;
    rd_n    = 1'b0;
    pend_n  = rd_en;
    da_n    = pend ? fifo_out : da_data;
    ur_n    = underrun & ~clr;
    if (!go) begin
      state_n = IDLE;
      acc_n   = '0;
      pend_n  = 1'b0;
      da_n    = MID;
    end else begin
      unique case (state)
        IDLE: state_n = PRE;
        PRE: begin
          if (full) begin
            state_n = PLAY;
            acc_n   = '0;
          end
        end
        PLAY: begin
          acc_n = tick ? (sum - MOD) : sum;
          if (tick) begin
            if (avail) begin
              rd_n = 1'b1;
            end else begin
              state_n = STARVE;
              ur_n    = 1'b1;
            end
          end
        end
        STARVE: begin
          if (full) state_n = PLAY;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      rd_en    <= 1'b0;
      pend     <= 1'b0;
      da_data  <= MID;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      rd_en    <= rd_n;
      pend     <= pend_n;
      da_data  <= da_n;
      underrun <= ur_n;
    end
  end
endmodule

module da_play_sched #(
  parameter int         CLK_HZ  = 50_000_000,
  parameter int         SPP     = 256,
  parameter int         PREFILL = 10,
  parameter logic [7:0] MID     = 8'h80,
  parameter int         ACC_W   = 27
) (
  input logic             clk,
  input logic             rst_n,
  da_play_sched_if.slave  bus
);
  da_play_ch #(
    .CLK_HZ(CLK_HZ), .SPP(SPP), .PREFILL(PREFILL),
    .MID(MID), .ACC_W(ACC_W)
  ) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en_a),
    .freq     (bus.freq_a),
    .count    (bus.rd_data_count_a),
    .fifo_out (bus.fifo_out_a),
    .clr      (bus.clr_status),
    .rd_en    (bus.rd_en_a),
    .da_data  (bus.da_data_a),
    .state_o  (bus.state_a),
    .underrun (bus.underrun_a)
  );

  da_play_ch #(
    .CLK_HZ(CLK_HZ), .SPP(SPP), .PREFILL(PREFILL),
    .MID(MID), .ACC_W(ACC_W)
  ) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en_b),
    .freq     (bus.freq_b),
    .count    (bus.rd_data_count_b),
    .fifo_out (bus.fifo_out_b),
    .clr      (bus.clr_status),
    .rd_en    (bus.rd_en_b),
    .da_data  (bus.da_data_b),
    .state_o  (bus.state_b),
    .underrun (bus.underrun_b)
  );
endmodule
